// File: rtl/core_pkg.sv
// Shared core definitions: ARM condition codes, NZCV bit positions and the
// hazard-controller state encoding.
package core_pkg;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } hz_state_e;

endpackage

// File: rtl/flag_hazard_ctrl_cond.sv
// conditionCheck: combinational ARM condition evaluator against an NZCV word.
module conditionCheck
  import core_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status_ID,
  output logic       pass
);

  logic n, z, c, v;

  assign n = status_ID[N_BIT];
  assign z = status_ID[Z_BIT];
  assign c = status_ID[C_BIT];
  assign v = status_ID[V_BIT];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// Owns the committed NZCV register, counts in-flight flag writers and stalls
// ID when a conditional instruction would read flags that are not yet final.
module flag_hazard_ctrl
  import core_pkg::*;
#(
  parameter int PEND_W = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [3:0]        id_cond,
  input  logic              id_s,
  input  logic              ex_flag_wr,
  input  logic [3:0]        ex_status,
  output logic [3:0]        status_ID,
  output logic              id_exec,
  output logic              id_stall,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              err_underflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PERF_MAX = '1;
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [3:0]        status_q, status_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic              err_q, err_d;
  hz_state_e         state_q, state_d;

  logic hazard, full, issue, inc, dec, count_stall;

  conditionCheck u_cond (
    .cond      (id_cond),
    .status_ID (status_q),
    .pass      (id_exec)
  );

  // Flags become visible only after the commit edge, so a stalled reader
  // releases one cycle after the last writer completes.
  assign hazard   = id_valid && (id_cond != COND_AL) && (pend_q != '0);
  assign full     = id_valid && id_s && (pend_q == PEND_MAX);
  assign id_stall = hazard || full;

  assign issue = id_valid && !id_stall && !freeze && !flush;
  assign inc   = issue && id_s && id_exec;
  assign dec   = ex_flag_wr && (pend_q != '0);

  assign count_stall = id_stall && !freeze && (state_q != ST_IDLE);

  always_comb begin
    pend_d   = pend_q;
    status_d = status_q;
    err_d    = err_q;
    perf_d   = perf_q;
    if (inc && !dec) begin
      pend_d = pend_q + PEND_ONE;
    end else if (dec && !inc) begin
      pend_d = pend_q - PEND_ONE;
    end
    if (ex_flag_wr) begin
      status_d = ex_status;
      if (pend_q == '0) begin
        err_d = 1'b1;
      end
    end
    if (count_stall && (perf_q != PERF_MAX)) begin
      perf_d = perf_q + PERF_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (inc && !dec) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (pend_d == '0)                        state_d = ST_IDLE;
        else if (id_stall && !freeze && !flush)  state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (pend_d == '0)              state_d = ST_IDLE;
        else if (flush || !id_stall)   state_d = ST_BUSY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      pend_q   <= '0;
      perf_q   <= '0;
      err_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      status_q <= status_d;
      pend_q   <= pend_d;
      perf_q   <= perf_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  assign status_ID     = status_q;
  assign pend_cnt      = pend_q;
  assign stall_cycles  = perf_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Directed bench for flag_hazard_ctrl: a reference model pushes expected
// values to a scoreboard queue which is drained against the DUT outputs.
module tb_flag_hazard_ctrl;

  localparam int PEND_W = 2;
  localparam int PERF_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              freeze, flush, id_valid, id_s, ex_flag_wr;
  logic [3:0]        id_cond, ex_status;
  logic [3:0]        status_ID;
  logic              id_exec, id_stall, err_underflow;
  logic [PEND_W-1:0] pend_cnt;
  logic [PERF_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  flag_hazard_ctrl #(.PEND_W(PEND_W), .PERF_W(PERF_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_cond       (id_cond),
    .id_s          (id_s),
    .ex_flag_wr    (ex_flag_wr),
    .ex_status     (ex_status),
    .status_ID     (status_ID),
    .id_exec       (id_exec),
    .id_stall      (id_stall),
    .pend_cnt      (pend_cnt),
    .stall_cycles  (stall_cycles),
    .err_underflow (err_underflow)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  localparam int SEL_STALL  = 0;
  localparam int SEL_EXEC   = 1;
  localparam int SEL_PEND   = 2;
  localparam int SEL_STATUS = 3;
  localparam int SEL_PERF   = 4;
  localparam int SEL_ERR    = 5;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  int         mPend;
  logic [3:0] mStatus;
  int         mPerf;
  logic       mErr;

  // Reference condition truth table, indexed by condition code.
  function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic [15:0] t;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    t  = {1'b0, 1'b1, z | (n ^ v), !z & !(n ^ v), n ^ v, !(n ^ v),
          !cf | z, cf & !z, !v, v, !n, n, !cf, cf, !z, z};
    return t[c];
  endfunction

  function automatic logic refStall(input logic v, input logic [3:0] c, input logic s);
    return v && (((c != 4'hE) && (mPend != 0)) || (s && (mPend == 3)));
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_STALL:  return {31'd0, id_stall};
      SEL_EXEC:   return {31'd0, id_exec};
      SEL_PEND:   return {30'd0, pend_cnt};
      SEL_STATUS: return {28'd0, status_ID};
      SEL_PERF:   return {16'd0, stall_cycles};
      default:    return {31'd0, err_underflow};
    endcase
  endfunction

  task automatic expectVal(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expectRegs(input string tag);
    expectVal({tag, "_pend"},   SEL_PEND,   mPend);
    expectVal({tag, "_status"}, SEL_STATUS, {28'd0, mStatus});
    expectVal({tag, "_perf"},   SEL_PERF,   mPerf);
    expectVal({tag, "_err"},    SEL_ERR,    {31'd0, mErr});
  endtask

  // One clock of stimulus; entered and left just after a rising edge.
  task automatic applyStimulus(input string tag, input logic v, input logic [3:0] c,
                               input logic s, input logic wr, input logic [3:0] st,
                               input logic frz, input logic fl);
    logic stall, exec, issue, inc, dec;
    id_valid   = v;
    id_cond    = c;
    id_s       = s;
    ex_flag_wr = wr;
    ex_status  = st;
    freeze     = frz;
    flush      = fl;
    @(negedge clk);
    stall = refStall(v, c, s);
    exec  = refCond(c, mStatus);
    expectVal({tag, "_stall"}, SEL_STALL, {31'd0, stall});
    expectVal({tag, "_exec"},  SEL_EXEC,  {31'd0, exec});
    checkOutput();
    issue = v && !stall && !frz && !fl;
    inc   = issue && s && exec;
    dec   = wr && (mPend != 0);
    if (wr) begin
      if (mPend == 0) mErr = 1'b1;
      mStatus = st;
    end
    if (inc && !dec) mPend = mPend + 1;
    else if (dec && !inc) mPend = mPend - 1;
    if (stall && !frz && (mPerf < 65535)) mPerf = mPerf + 1;
    @(posedge clk);
    #1;
    expectRegs(tag);
    checkOutput();
  endtask

  task automatic modelReset();
    mPend   = 0;
    mStatus = 4'h0;
    mPerf   = 0;
    mErr    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    freeze = 1'b0; flush = 1'b0; id_valid = 1'b0; id_s = 1'b0;
    ex_flag_wr = 1'b0; id_cond = 4'h0; ex_status = 4'h0;
    modelReset();
    #3;
    expectVal("rst_stall", SEL_STALL, 0);
    expectVal("rst_exec",  SEL_EXEC,  0);
    expectRegs("rst");
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Conditional S instruction failing its condition does not count
    applyStimulus("condfail", 1, 4'h0, 1, 0, 4'h0, 0, 0);
    expectVal("condfail_pend0", SEL_PEND, 0);
    checkOutput();

    // SUBS then BEQ stalled until the commit
    applyStimulus("subs", 1, 4'hE, 1, 0, 4'h0, 0, 0);
    applyStimulus("beq1", 1, 4'h0, 0, 0, 4'h0, 0, 0);
    applyStimulus("beq2", 1, 4'h0, 0, 1, 4'b0100, 0, 0);
    expectVal("A_release_stall", SEL_STALL, 0);
    expectVal("A_release_exec",  SEL_EXEC,  1);
    expectVal("A_perf",          SEL_PERF,  2);
    checkOutput();
    applyStimulus("beq3", 1, 4'h0, 0, 0, 4'h0, 0, 0);

    // Fill the counter, stall on full, release with a same-cycle writeback
    applyStimulus("adds1", 1, 4'hE, 1, 0, 4'h0, 0, 0);
    applyStimulus("adds2", 1, 4'hE, 1, 0, 4'h0, 0, 0);
    applyStimulus("adds3", 1, 4'hE, 1, 0, 4'h0, 0, 0);
    applyStimulus("full1", 1, 4'hE, 1, 0, 4'h0, 0, 0);
    applyStimulus("full2", 1, 4'hE, 1, 1, 4'h0, 0, 0);
    expectVal("full_release_stall", SEL_STALL, 0);
    expectVal("full_release_pend",  SEL_PEND,  2);
    expectVal("full_perf",          SEL_PERF,  4);
    checkOutput();
    applyStimulus("full3", 1, 4'hE, 1, 0, 4'h0, 0, 0);
    expectVal("full_refill_pend", SEL_PEND, 3);
    checkOutput();

    // Drain to one, then simultaneous increment and decrement
    applyStimulus("drain1", 0, 4'h0, 0, 1, 4'h0, 0, 0);
    applyStimulus("drain2", 0, 4'h0, 0, 1, 4'h0, 0, 0);
    applyStimulus("incdec", 1, 4'hE, 1, 1, 4'b1010, 0, 0);
    expectVal("incdec_pend",   SEL_PEND,   1);
    expectVal("incdec_status", SEL_STATUS, 4'b1010);
    checkOutput();

    // Freeze blocks issue; frozen hazard stalls are not counted
    applyStimulus("frz1", 1, 4'hE, 1, 0, 4'h0, 1, 0);
    applyStimulus("frz2", 1, 4'hE, 1, 0, 4'h0, 1, 0);
    applyStimulus("frz3", 1, 4'hE, 1, 0, 4'h0, 1, 0);
    expectVal("frz_pend", SEL_PEND, 1);
    expectVal("frz_perf", SEL_PERF, 4);
    checkOutput();
    applyStimulus("unfrz", 1, 4'hE, 1, 0, 4'h0, 0, 0);
    expectVal("unfrz_pend", SEL_PEND, 2);
    checkOutput();
    applyStimulus("frzhaz", 1, 4'h0, 0, 0, 4'h0, 1, 0);
    expectVal("frzhaz_perf", SEL_PERF, 4);
    checkOutput();

    // Underflow commits the flags and sets the sticky error
    applyStimulus("drain3", 0, 4'h0, 0, 1, 4'b1010, 0, 0);
    applyStimulus("drain4", 0, 4'h0, 0, 1, 4'b1010, 0, 0);
    applyStimulus("under", 0, 4'h0, 0, 1, 4'b0010, 0, 0);
    expectVal("under_status", SEL_STATUS, 4'b0010);
    expectVal("under_err",    SEL_ERR,    1);
    checkOutput();
    applyStimulus("under_hold", 0, 4'h0, 0, 0, 4'h0, 0, 0);
    expectVal("under_sticky", SEL_ERR, 1);
    checkOutput();

    // Flush squashes the issue
    applyStimulus("flush", 1, 4'h2, 1, 0, 4'h0, 0, 1);
    expectVal("flush_pend", SEL_PEND, 0);
    checkOutput();

    // Asynchronous reset mid-stream with two writers pending
    applyStimulus("pre1", 1, 4'h2, 1, 0, 4'h0, 0, 0);
    applyStimulus("pre2", 1, 4'hE, 1, 0, 4'h0, 0, 0);
    id_valid = 1'b1; id_cond = 4'h0; id_s = 1'b0;
    #1;
    expectVal("prerst_stall", SEL_STALL, {31'd0, refStall(1'b1, 4'h0, 1'b0)});
    expectVal("prerst_pend",  SEL_PEND,  2);
    checkOutput();
    #1;
    rst = 1'b1;
    #1;
    modelReset();
    expectVal("midrst_stall", SEL_STALL, 0);
    expectRegs("midrst");
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("post", 1, 4'hE, 1, 0, 4'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_hazard_ctrl.md
Name: flag_hazard_ctrl

Overview:
- Owns the architectural NZCV status register for the ARM32 core.
- Tracks flag-setting (S-bit) instructions issued from ID but not yet written back from EX.
- Stalls ID when a conditional instruction needs flags that are still in flight.
- Wraps the condition evaluator, so ID receives a single "execute / don't execute" decision and a stall.

Parameters:
- PEND_W, 2, width of the in-flight flag-writer counter. Maximum outstanding writers is 2^PEND_W-1.
- PERF_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  global pipeline freeze from the cache/memory stall. Blocks issue accounting.
- flush  in  1  branch taken in EX. The instruction currently in ID is squashed.
- id_valid  in  1  ID holds a valid instruction.
- id_cond  in  4  condition field of the ID instruction (0000 EQ … 1110 AL, 1111 never).
- id_s  in  1  ID instruction updates flags.
- ex_flag_wr  in  1  EX completes a flag-setting instruction this cycle.
- ex_status  in  4  new {N,Z,C,V} from the ALU, valid with ex_flag_wr.
- status_ID  out  4  current committed {N,Z,C,V}.
- id_exec  out  1  ID instruction's condition passes against status_ID.
- id_stall  out  1  hold IF/ID this cycle.
- pend_cnt  out  PEND_W  number of in-flight flag writers.
- stall_cycles  out  PERF_W  saturating count of flag-hazard stall cycles.
- err_underflow  out  1  sticky: ex_flag_wr arrived while pend_cnt==0.

Behaviour:
- Reset (async, rst=1): status_ID=0000, pend_cnt=0, stall_cycles=0, err_underflow=0, FSM=IDLE. Outputs settle immediately, without waiting for a clk edge. Asserting reset mid-operation discards all pending state.

id_exec:
- Combinational evaluation of id_cond against status_ID, using standard ARM semantics.
- Cond 1110 gives 1; cond 1111 gives 0.

id_stall (combinational from registered state and ID inputs), asserted when id_valid=1 and any of:
- id_cond!=1110 and pend_cnt!=0 (flag hazard; a stall for cond 1111 with writers pending is acceptable).
- id_s=1 and pend_cnt==2^PEND_W-1 (counter full).

Issue event: id_valid & !id_stall & !freeze & !flush.

Counter update per posedge:
- inc = issue & id_s & id_exec.
- dec = ex_flag_wr & (pend_cnt!=0).
- inc & dec: unchanged.
- inc only: +1.
- dec only: −1.
- Never wraps.
- A conditional S instruction that fails its condition does not increment.

Flag commit:
- ex_flag_wr=1 loads status_ID <= ex_status at the edge, regardless of freeze.
- There is no same-cycle bypass: a stalled ID instruction sees new flags and releases one cycle after the final ex_flag_wr.

Underflow:
- ex_flag_wr with pend_cnt==0 still commits the flags.
- Sets err_underflow, which stays set until reset.

flush:
- Suppresses the issue event only. In-flight writers are older than the branch and still complete.

freeze:
- id_stall still reflects hazards, but issue is blocked.
- stall_cycles does not count frozen cycles.

FSM (registered, for sequencing and perf):
- IDLE (pend_cnt==0):
  - goes to BUSY on inc without dec.
- BUSY (pend_cnt>0, no hazard):
  - goes to HOLD when id_stall & !freeze & !flush;
  - goes to IDLE when the next count is 0.
- HOLD:
  - increments stall_cycles every cycle with id_stall & !freeze, saturating at all-ones;
  - goes to BUSY when the hazard clears and the next count is >0;
  - goes to IDLE when the next count is 0;
  - goes to BUSY or IDLE on flush.
- The hazard-stall cycle that causes the BUSY→HOLD transition also increments stall_cycles. The count therefore equals the number of id_stall & !freeze cycles caused by a flag hazard.
- A full-counter stall (id_s with pend_cnt at maximum) is a hazard stall: it drives the BUSY→HOLD transition and increments stall_cycles like any other flag-hazard stall.

Decomposition:
- Shared package (core_pkg):
  - cond_e enum of the 16 condition codes;
  - NZCV bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0;
  - COND_AL=4'b1110.
- One sub-module: the existing conditionCheck evaluator, instantiated for id_exec (cond=id_cond, status_ID=status_ID). No new evaluator is written.
- Counter, FSM and perf counter stay in flag_hazard_ctrl.

Test Plan:
- Reset with rst pulsed mid-stream while pend_cnt=2 → immediately status_ID=0000, pend_cnt=0, id_stall=0, stall_cycles=0, err_underflow=0.
- Issue SUBS (cond AL, id_s=1), then BEQ (id_cond=0000) the next cycle; ex_flag_wr=1 with ex_status=0100 two cycles later:
  - BEQ id_stall=1 for 2 cycles, 0 the cycle after the commit;
  - id_exec=1 on release;
  - stall_cycles=2.
- pend_cnt=3 (PEND_W=2) and ID holds ADDS AL → id_stall=1, stall_cycles increments per stall cycle; same-cycle ex_flag_wr → next cycle pend_cnt=2, id_stall=0, issue raises pend_cnt back to 3.
- Simultaneous inc and dec at pend_cnt=1 → pend_cnt stays 1; status_ID takes ex_status=1010.
- freeze=1 for 3 cycles with an issuable ADDS in ID → pend_cnt unchanged, stall_cycles unchanged. Unfreeze → pend_cnt+1.
- ex_flag_wr=1 with pend_cnt=0 and ex_status=0010 → status_ID=0010, err_underflow=1 and stays set; flush during a pending issue → no increment.
